execute_stage_mdu: RTL and testbench
====================================

Name: execute_stage_mdu

Overview:
- Parametrised next-generation execute stage for the pipelined MIPS core.
- Contains the ID/EX pipeline register with stall and flush, A/B forwarding muxes, the destination-register mux and a single-cycle ALU.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers. The MDU reports busy and interlock status to the hazard unit.
- Sits between decode and memory stages; WriteRegE, RsE and RtE feed the hazard unit.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, even).
- REG_ADDR_W, 5, register-specifier width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- StallE  in  1  hold ID/EX register
- FlushE  in  1  load bubble into ID/EX register
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode controls
- ALUControlD  in  4  operation code
- RD1D, RD2D, SignImmD  in  WIDTH  operands
- RsD, RtD, RdD  in  REG_ADDR_W  register specifiers
- ResultW, ALUOutM  in  WIDTH  forwarding sources
- ForwardAE, ForwardBE  in  2  forward selects
- RegWriteE, MemtoRegE, MemWriteE  out  1  registered controls
- RsE, RtE  out  REG_ADDR_W  registered specifiers
- WriteRegE  out  REG_ADDR_W  RegDstE ? RdE : RtE
- WriteDataE  out  WIDTH  forwarded B operand
- ALUOutE  out  WIDTH  ALU or HI/LO result
- MdBusyE  out  1  MDU not IDLE
- MdStallE  out  1  instruction in E must wait for MDU

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset:
  - All ID/EX fields, HI, LO and the started flag clear to 0.
  - MDU enters IDLE.
  - Combinational outputs then follow the cleared state.
- ID/EX register update priority per edge: reset > FlushE (all fields 0) > StallE (hold) > load from D.
- Forward select codes: 0 = RDxE, 1 = ResultW, 2 = ALUOutM, 3 = RDxE.
- Operand routing:
  - SrcAE = forwarded A.
  - WriteDataE = forwarded B.
  - SrcBE = ALUSrcE ? SignImmE : forwarded B.
- ALUControl encodings:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLTU, 6 SUB, 7 SLT (signed).
  - 8 MULT, 9 MULTU, 10 DIV, 11 DIVU, 12 MFHI, 13 MFLO.
  - 14 and 15 produce 0.
- ALU result rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SLTU produce 0 or 1, zero-extended.
  - MD ops (8–11) produce ALUOutE = 0.
  - MFHI/MFLO produce ALUOutE = HI/LO.
- MDU states: IDLE → RUN (WIDTH cycles, radix-2 shift-add or restoring divide on magnitudes) → FIX (sign correction, writes HI/LO) → IDLE.
  - Launch-to-HI/LO-valid latency is WIDTH+1 cycles.
- Launch condition: E holds an MD op, MDU is IDLE, and StartedE=0. Operands are SrcAE and forwarded B captured at launch.
- StartedE:
  - Set at launch.
  - Cleared whenever the ID/EX register loads or flushes.
  - Prevents relaunch while the op is held by StallE.
- MdStallE = (E holds MFHI, MFLO or an MD op) and MdBusyE.
  - The hazard unit must convert MdStallE into StallE, StallD and StallF.
  - MdStallE falls in the cycle MDU returns to IDLE; MFHI/MFLO then read the new HI/LO.
- Results:
  - MULT/MULTU: {HI,LO} = full 2·WIDTH product.
  - DIV/DIVU: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend.
- Signed overflow (MIN / −1): LO = MIN, HI = 0.
- FlushE while MDU is running: the running operation completes and writes HI/LO (already committed). Only the E register is bubbled.
- Reset mid-operation: the MDU aborts to IDLE and HI/LO are cleared.

Optional Feature:
- Macro: EX_MDU_DIV_EN.
- Defined: DIV/DIVU supported as above.
- Undefined:
  - Divider datapath is omitted.
  - DIV/DIVU behave as NOP: no launch, HI/LO unchanged, MdStallE only from other ops, ALUOutE = 0.
  - MULT/MULTU/MFHI/MFLO are unaffected.

Decomposition:
- Package ex_pkg holds:
  - ALUControl encoding constants.
  - Forward-select constants.
  - MDU state enum (IDLE, RUN, FIX).
- Sub-module ex_mdu: FSM, iteration counter, HI/LO registers, busy.
  - Parameterised by WIDTH.
  - Interface: start, op, a, b, busy, hi, lo.

Test Plan:
- Writeback mux: RtD=12, RdD=16, RegDstD=0 then 1, then FlushE=1 → WriteRegE = 12, then 16, then 0.
- Forwarding: RD2D=42, ResultW=32, ALUOutM=22, ForwardBE = 0/1/2/3 → WriteDataE = 42/32/22/42. StallE=1 with RD2D changed → WriteDataE unchanged.
- Signed multiply: MULT, SrcA=7, SrcB=0xFFFFFFFD → MdBusyE high 33 cycles. Following MFLO asserts MdStallE until IDLE, then ALUOutE = 0xFFFFFFEB. MFHI → 0xFFFFFFFF.
- Divide (EX_MDU_DIV_EN): DIV 7 / −2 → LO = 0xFFFFFFFD, HI = 1. DIVU 7/0 → LO = 0xFFFFFFFF, HI = 7. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- No relaunch under stall: MULTU 3×5 held by StallE for 40 cycles → exactly one launch, LO = 15, HI = 0. Without EX_MDU_DIV_EN, DIV leaves HI/LO unchanged and MdBusyE stays 0.
- Reset mid-op: rst_n=0 at cycle 10 of a MULT → next edge MdBusyE=0, HI=LO=0, all E outputs 0.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage and its multiply/divide unit.
// EX_MDU_DIV_EN adds DIV/DIVU to the set of ops that launch the MDU.
package ex_pkg;
  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_XOR   = 4'd3;
  localparam logic [3:0] ALU_NOR   = 4'd4;
  localparam logic [3:0] ALU_SLTU  = 4'd5;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_MULT  = 4'd8;
  localparam logic [3:0] ALU_MULTU = 4'd9;
  localparam logic [3:0] ALU_DIV   = 4'd10;
  localparam logic [3:0] ALU_DIVU  = 4'd11;
  localparam logic [3:0] ALU_MFHI  = 4'd12;
  localparam logic [3:0] ALU_MFLO  = 4'd13;

  localparam logic [1:0] FWD_RD   = 2'd0;
  localparam logic [1:0] FWD_RESW = 2'd1;
  localparam logic [1:0] FWD_ALUM = 2'd2;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} mdState_t;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memWrite;
    logic       aluSrc;
    logic       regDst;
    logic [3:0] aluControl;
  } exCtrl_t;

  // Ops that occupy the MDU; without the divider DIV/DIVU are plain NOPs.
  function automatic logic isMdOp(input logic [3:0] c);
`ifdef EX_MDU_DIV_EN
    return c inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
`else
    return c inside {ALU_MULT, ALU_MULTU};
`endif
  endfunction
endpackage

// File: rtl/execute_stage_mdu_if.sv
// Decode-side inputs, forwarding sources and E-stage outputs of the execute stage.
interface execute_stage_mdu_if #(parameter int WIDTH = 32, parameter int REG_ADDR_W = 5);
  logic                  StallE, FlushE;
  logic                  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [3:0]            ALUControlD;
  logic [WIDTH-1:0]      RD1D, RD2D, SignImmD;
  logic [REG_ADDR_W-1:0] RsD, RtD, RdD;
  logic [WIDTH-1:0]      ResultW, ALUOutM;
  logic [1:0]            ForwardAE, ForwardBE;
  logic                  RegWriteE, MemtoRegE, MemWriteE;
  logic [REG_ADDR_W-1:0] RsE, RtE, WriteRegE;
  logic [WIDTH-1:0]      WriteDataE, ALUOutE;
  logic                  MdBusyE, MdStallE;

  modport master (
    output StallE, FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
           RD1D, RD2D, SignImmD, RsD, RtD, RdD, ResultW, ALUOutM, ForwardAE, ForwardBE,
    input  RegWriteE, MemtoRegE, MemWriteE, RsE, RtE, WriteRegE, WriteDataE, ALUOutE,
           MdBusyE, MdStallE
  );
  modport slave (
    input  StallE, FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
           RD1D, RD2D, SignImmD, RsD, RtD, RdD, ResultW, ALUOutM, ForwardAE, ForwardBE,
    output RegWriteE, MemtoRegE, MemWriteE, RsE, RtE, WriteRegE, WriteDataE, ALUOutE,
           MdBusyE, MdStallE
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative radix-2 multiply / restoring divide on magnitudes with HI/LO registers.
// The divider datapath exists only when EX_MDU_DIV_EN is defined.
module ex_mdu import ex_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,      // {div, unsigned}
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  mdState_t           state, nextState;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, accNext, fixed;
  logic [WIDTH-1:0]   opB, aMag, bMag;
  logic [WIDTH:0]     sum;
  logic               aNeg, bNeg, negQ;
`ifdef EX_MDU_DIV_EN
  logic               isDiv, negR;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH:0]     remSh, diff;
`else
  logic               unusedOp;
  assign unusedOp = op[1];
`endif

  assign aNeg = !op[0] && a[WIDTH-1];
  assign bNeg = !op[0] && b[WIDTH-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;
  assign busy = (state != MD_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      MD_IDLE: if (start) nextState = MD_RUN;
      MD_RUN:  if (cnt == CW'(WIDTH-1)) nextState = MD_FIX;
      MD_FIX:  nextState = MD_IDLE;
      default: nextState = MD_IDLE;
    endcase
  end

  // One iteration: multiply shifts right adding the multiplicand, divide shifts left subtracting.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
    accNext = {sum, acc[WIDTH-1:1]};
`ifdef EX_MDU_DIV_EN
    remSh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = remSh - {1'b0, opB};
    if (isDiv)
      accNext = diff[WIDTH] ? {remSh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
`endif
  end

  always_comb begin
    fixed = negQ ? -acc : acc;
`ifdef EX_MDU_DIV_EN
    if (isDiv) begin
      fixed[WIDTH-1:0]       = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fixed[2*WIDTH-1:WIDTH] = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      // Divide by zero; MIN/-1 already falls out of the magnitude path.
      if (opB == '0) fixed = {dvd, {WIDTH{1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0; acc <= '0; opB <= '0; negQ <= 1'b0; hi <= '0; lo <= '0;
`ifdef EX_MDU_DIV_EN
      isDiv <= 1'b0; negR <= 1'b0; dvd <= '0;
`endif
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          cnt  <= '0;
          acc  <= {{WIDTH{1'b0}}, aMag};
          opB  <= bMag;
          negQ <= aNeg ^ bNeg;
`ifdef EX_MDU_DIV_EN
          isDiv <= op[1];
          negR  <= aNeg;
          dvd   <= a;
`endif
        end
        MD_RUN: begin
          acc <= accNext;
          cnt <= cnt + 1'b1;
        end
        MD_FIX:  {hi, lo} <= fixed;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/execute_stage_mdu.sv
// MIPS execute stage: ID/EX register, forwarding, ALU and an iterative MDU.
// Define EX_MDU_DIV_EN to include DIV/DIVU support.
module execute_stage_mdu import ex_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic clk,
  input logic rst_n,
  execute_stage_mdu_if.slave bus
);
  exCtrl_t               ctrlE;
  logic [WIDTH-1:0]      rd1E, rd2E, immE, srcA, fwdB, srcB, hi, lo, aluOut;
  logic [REG_ADDR_W-1:0] rsE, rtE, rdE;
  logic                  startedE, launch, mdBusy, mdOpE;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushE) begin
      ctrlE <= '0; rd1E <= '0; rd2E <= '0; immE <= '0;
      rsE <= '0; rtE <= '0; rdE <= '0; startedE <= 1'b0;
    end else if (!bus.StallE) begin
      ctrlE    <= '{bus.RegWriteD, bus.MemtoRegD, bus.MemWriteD, bus.ALUSrcD, bus.RegDstD,
                    bus.ALUControlD};
      rd1E     <= bus.RD1D;
      rd2E     <= bus.RD2D;
      immE     <= bus.SignImmD;
      rsE      <= bus.RsD;
      rtE      <= bus.RtD;
      rdE      <= bus.RdD;
      startedE <= 1'b0;
    end else if (launch) begin
      // A stalled MD op must not relaunch once it has been handed to the MDU.
      startedE <= 1'b1;
    end
  end

  always_comb begin
    case (bus.ForwardAE)
      FWD_RESW: srcA = bus.ResultW;
      FWD_ALUM: srcA = bus.ALUOutM;
      default:  srcA = rd1E;
    endcase
    case (bus.ForwardBE)
      FWD_RESW: fwdB = bus.ResultW;
      FWD_ALUM: fwdB = bus.ALUOutM;
      default:  fwdB = rd2E;
    endcase
    srcB = ctrlE.aluSrc ? immE : fwdB;
  end

  assign mdOpE  = isMdOp(ctrlE.aluControl);
  assign launch = mdOpE && !mdBusy && !startedE;

  ex_mdu #(.WIDTH(WIDTH)) u_mdu (
    .clk(clk), .rst_n(rst_n), .start(launch), .op(ctrlE.aluControl[1:0]),
    .a(srcA), .b(fwdB), .busy(mdBusy), .hi(hi), .lo(lo)
  );

  always_comb begin
    aluOut = '0;
    case (ctrlE.aluControl)
      ALU_AND:  aluOut = srcA & srcB;
      ALU_OR:   aluOut = srcA | srcB;
      ALU_ADD:  aluOut = srcA + srcB;
      ALU_XOR:  aluOut = srcA ^ srcB;
      ALU_NOR:  aluOut = ~(srcA | srcB);
      ALU_SLTU: aluOut = {{(WIDTH-1){1'b0}}, srcA < srcB};
      ALU_SUB:  aluOut = srcA - srcB;
      ALU_SLT:  aluOut = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
      ALU_MFHI: aluOut = hi;
      ALU_MFLO: aluOut = lo;
      default:  aluOut = '0;
    endcase
  end

  assign bus.RegWriteE  = ctrlE.regWrite;
  assign bus.MemtoRegE  = ctrlE.memtoReg;
  assign bus.MemWriteE  = ctrlE.memWrite;
  assign bus.RsE        = rsE;
  assign bus.RtE        = rtE;
  assign bus.WriteRegE  = ctrlE.regDst ? rdE : rtE;
  assign bus.WriteDataE = fwdB;
  assign bus.ALUOutE    = aluOut;
  assign bus.MdBusyE    = mdBusy;
  assign bus.MdStallE   = mdBusy && (mdOpE || ctrlE.aluControl inside {ALU_MFHI, ALU_MFLO});
endmodule

// File: tb/tb_execute_stage_mdu.sv
// Randomized self-checking bench for execute_stage_mdu against an arithmetic reference model.
module tb_execute_stage_mdu;
  localparam int W  = 32;
  localparam int RA = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   nCmp = 0, nErr = 0;
  logic [W-1:0] mHi = '0, mLo = '0;

  always #5 clk = ~clk;

  execute_stage_mdu_if #(.WIDTH(W), .REG_ADDR_W(RA)) bus ();
  execute_stage_mdu #(.WIDTH(W), .REG_ADDR_W(RA)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clearD();
    bus.StallE = 0; bus.FlushE = 0;
    bus.RegWriteD = 0; bus.MemtoRegD = 0; bus.MemWriteD = 0; bus.ALUSrcD = 0; bus.RegDstD = 0;
    bus.ALUControlD = 0; bus.RD1D = 0; bus.RD2D = 0; bus.SignImmD = 0;
    bus.RsD = 0; bus.RtD = 0; bus.RdD = 0; bus.ResultW = 0; bus.ALUOutM = 0;
    bus.ForwardAE = 0; bus.ForwardBE = 0;
  endtask

  task automatic loadOp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    clearD();
    bus.ALUControlD = op; bus.RD1D = a; bus.RD2D = b;
    tick();
  endtask

  function automatic logic [W-1:0] aluRef(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a ^ b;
      4'd4: return ~(a | b);
      4'd5: return (a < b) ? W'(1) : W'(0);
      4'd6: return a - b;
      4'd7: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] fwdRef(input logic [1:0] s, input logic [W-1:0] rd,
                                          input logic [W-1:0] resW, input logic [W-1:0] aluM);
    return (s == 2'd1) ? resW : (s == 2'd2) ? aluM : rd;
  endfunction

  // Updates model HI/LO the way the ISA defines each MD op.
  task automatic mdRef(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint     sp;
    logic [63:0] up;
    int         sa, sb;
    sa = $signed(a); sb = $signed(b);
    case (op)
      4'd8: begin sp = longint'(sa) * longint'(sb); {mHi, mLo} = sp; end
      4'd9: begin up = 64'(a) * 64'(b); {mHi, mLo} = up; end
      4'd10: begin
        if (b == 0) begin mLo = '1; mHi = a; end
        else if (a == 32'h8000_0000 && sb == -1) begin mLo = a; mHi = 0; end
        else begin mLo = sa / sb; mHi = sa % sb; end
      end
      4'd11: begin
        if (b == 0) begin mLo = '1; mHi = a; end
        else begin mLo = a / b; mHi = a % b; end
      end
      default: ;
    endcase
  endtask

  task automatic readHiLo(output logic [W-1:0] h, output logic [W-1:0] l);
    clearD(); bus.ALUControlD = 4'd12; tick(); h = bus.ALUOutE;
    bus.ALUControlD = 4'd13; tick(); l = bus.ALUOutE;
    bus.ALUControlD = 4'd0;
  endtask

  // Issue an MD op, follow with MFLO stalled on MdStallE (hazard unit role), then MFHI.
  task automatic runMd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int busyCnt = 0;
    loadOp(op, a, b);
    mdRef(op, a, b);
    nCmp++;
    if (bus.ALUOutE !== '0) begin
      nErr++; $display("FAIL md_aluout_zero op=%0d: got %h want 0", op, bus.ALUOutE);
    end
    clearD(); bus.ALUControlD = 4'd13;
    tick();
    while (bus.MdStallE === 1'b1 && busyCnt < 100) begin
      bus.StallE = 1; busyCnt++; tick();
    end
    nCmp++;
    if (busyCnt != W + 1) begin
      nErr++; $display("FAIL md_busy_cycles op=%0d: got %0d want %0d", op, busyCnt, W + 1);
    end
    nCmp++;
    if (bus.ALUOutE !== mLo) begin
      nErr++; $display("FAIL md_lo op=%0d a=%h b=%h: got %h want %h", op, a, b, bus.ALUOutE, mLo);
    end
    bus.StallE = 0; bus.ALUControlD = 4'd12;
    tick();
    nCmp++;
    if (bus.ALUOutE !== mHi) begin
      nErr++; $display("FAIL md_hi op=%0d a=%h b=%h: got %h want %h", op, a, b, bus.ALUOutE, mHi);
    end
    bus.ALUControlD = 4'd0;
    tick();
  endtask

  task automatic test_reset();
    clearD();
    bus.RegWriteD = 1; bus.RegDstD = 1; bus.RdD = 5'd9; bus.RD2D = 32'h1234; bus.ALUControlD = 4'd2;
    bus.RD1D = 32'h55;
    rst_n = 0;
    tick(); tick();
    nCmp++; if (bus.RegWriteE !== 1'b0) begin nErr++; $display("FAIL reset_regwrite: got %b want 0", bus.RegWriteE); end
    nCmp++; if (bus.WriteRegE !== '0) begin nErr++; $display("FAIL reset_writereg: got %h want 0", bus.WriteRegE); end
    nCmp++; if (bus.ALUOutE !== '0) begin nErr++; $display("FAIL reset_aluout: got %h want 0", bus.ALUOutE); end
    nCmp++; if (bus.WriteDataE !== '0) begin nErr++; $display("FAIL reset_writedata: got %h want 0", bus.WriteDataE); end
    nCmp++; if (bus.MdBusyE !== 1'b0) begin nErr++; $display("FAIL reset_busy: got %b want 0", bus.MdBusyE); end
    rst_n = 1; mHi = '0; mLo = '0;
    clearD(); tick();
  endtask

  task automatic test_wb_mux();
    logic [RA-1:0] exp [3] = '{5'd12, 5'd16, 5'd0};
    clearD(); bus.RtD = 5'd12; bus.RdD = 5'd16;
    for (int i = 0; i < 3; i++) begin
      bus.RegDstD = (i != 0); bus.FlushE = (i == 2);
      tick();
      nCmp++;
      if (bus.WriteRegE !== exp[i]) begin
        nErr++; $display("FAIL wb_mux step %0d: got %0d want %0d", i, bus.WriteRegE, exp[i]);
      end
    end
    clearD();
  endtask

  task automatic test_forward();
    logic [W-1:0] exp;
    clearD(); bus.RD2D = 42; bus.ResultW = 32; bus.ALUOutM = 22;
    tick();
    for (int s = 0; s < 4; s++) begin
      bus.ForwardBE = 2'(s); #1;
      exp = fwdRef(2'(s), 42, 32, 22);
      nCmp++;
      if (bus.WriteDataE !== exp) begin
        nErr++; $display("FAIL forward_b sel=%0d: got %0d want %0d", s, bus.WriteDataE, exp);
      end
    end
    bus.ForwardBE = 0; bus.StallE = 1; bus.RD2D = 99;
    tick();
    nCmp++;
    if (bus.WriteDataE !== 42) begin
      nErr++; $display("FAIL forward_stall_hold: got %0d want 42", bus.WriteDataE);
    end
    clearD();
  endtask

  task automatic test_alu_random();
    logic [3:0] op; logic [W-1:0] a, b, imm, rw, am, fa, fb, expAlu;
    logic [RA-1:0] rs, rt, rd; logic src, dst; logic [2:0] ctl;
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 9);
      op = (k < 8) ? 4'(k) : 4'(k + 6);
      a = $urandom; b = $urandom; imm = $urandom; rw = $urandom; am = $urandom;
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      src = 1'($urandom); dst = 1'($urandom); ctl = 3'($urandom);
      clearD();
      bus.ALUControlD = op; bus.RD1D = a; bus.RD2D = b; bus.SignImmD = imm;
      bus.ALUSrcD = src; bus.RegDstD = dst; {bus.RegWriteD, bus.MemtoRegD, bus.MemWriteD} = ctl;
      bus.RsD = rs; bus.RtD = rt; bus.RdD = rd; bus.ResultW = rw; bus.ALUOutM = am;
      bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
      tick();
      fa = fwdRef(bus.ForwardAE, a, rw, am);
      fb = fwdRef(bus.ForwardBE, b, rw, am);
      expAlu = aluRef(op, fa, src ? imm : fb);
      nCmp++;
      if (bus.ALUOutE !== expAlu) begin
        nErr++; $display("FAIL alu op=%0d a=%h b=%h: got %h want %h", op, fa, fb, bus.ALUOutE, expAlu);
      end
      nCmp++;
      if (bus.WriteDataE !== fb || bus.WriteRegE !== (dst ? rd : rt) || bus.RsE !== rs || bus.RtE !== rt ||
          {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE} !== ctl) begin
        nErr++; $display("FAIL pipe_fields iter %0d: got wd=%h wr=%0d rs=%0d rt=%0d ctl=%b want wd=%h wr=%0d rs=%0d rt=%0d ctl=%b",
          i, bus.WriteDataE, bus.WriteRegE, bus.RsE, bus.RtE, {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE},
          fb, dst ? rd : rt, rs, rt, ctl);
      end
    end
    clearD(); tick();
  endtask

  task automatic test_mult();
    logic [W-1:0] edgeV [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF};
    runMd(4'd8, 32'd7, 32'hFFFF_FFFD);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a = $urandom, b = $urandom;
      if (i < 2) begin a = edgeV[$urandom_range(0, 3)]; b = edgeV[$urandom_range(0, 3)]; end
      runMd((i % 2) ? 4'd9 : 4'd8, a, b);
    end
  endtask

  task automatic test_no_relaunch();
    int busyCnt = 0, launches = 0; logic prev = 0; logic [W-1:0] h, l;
    loadOp(4'd9, 32'd3, 32'd5);
    mdRef(4'd9, 32'd3, 32'd5);
    bus.StallE = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.MdBusyE === 1'b1) busyCnt++;
      if (bus.MdBusyE === 1'b1 && !prev) launches++;
      prev = bus.MdBusyE;
    end
    nCmp++; if (launches != 1) begin nErr++; $display("FAIL no_relaunch_launches: got %0d want 1", launches); end
    nCmp++; if (busyCnt != W + 1) begin nErr++; $display("FAIL no_relaunch_busy: got %0d want %0d", busyCnt, W + 1); end
    readHiLo(h, l);
    nCmp++; if (l !== mLo) begin nErr++; $display("FAIL no_relaunch_lo: got %h want %h", l, mLo); end
    nCmp++; if (h !== mHi) begin nErr++; $display("FAIL no_relaunch_hi: got %h want %h", h, mHi); end
  endtask

`ifdef EX_MDU_DIV_EN
  task automatic test_div();
    runMd(4'd10, 32'd7, 32'hFFFF_FFFE);
    runMd(4'd11, 32'd7, 32'd0);
    runMd(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    runMd(4'd10, 32'hFFFF_FFF0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a = $urandom, b = $urandom;
      if (i % 3 == 0) b = b >> $urandom_range(0, 30);
      runMd((i % 2) ? 4'd11 : 4'd10, a, b);
    end
  endtask
`else
  task automatic test_div();
    logic [W-1:0] h, l; logic sawBusy = 0, sawOut = 0;
    runMd(4'd9, $urandom, $urandom);
    loadOp(4'd10, 32'd100, 32'd7);
    bus.StallE = 1;
    for (int i = 0; i < 5; i++) begin
      if (bus.MdBusyE !== 1'b0 || bus.MdStallE !== 1'b0) sawBusy = 1;
      if (bus.ALUOutE !== '0) sawOut = 1;
      tick();
    end
    nCmp++; if (sawBusy) begin nErr++; $display("FAIL div_disabled_busy: got busy/stall high want 0"); end
    nCmp++; if (sawOut) begin nErr++; $display("FAIL div_disabled_aluout: got nonzero want 0"); end
    readHiLo(h, l);
    nCmp++; if (h !== mHi || l !== mLo) begin
      nErr++; $display("FAIL div_disabled_hilo: got hi=%h lo=%h want hi=%h lo=%h", h, l, mHi, mLo);
    end
  endtask
`endif

  task automatic test_reset_midop();
    logic [W-1:0] h, l;
    loadOp(4'd8, $urandom, $urandom);
    bus.RegWriteD = 1; bus.RtD = 5'd7; bus.RsD = 5'd3; bus.RD2D = 32'hABCD;
    bus.StallE = 1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 0;
    tick();
    nCmp++; if (bus.MdBusyE !== 1'b0) begin nErr++; $display("FAIL midop_reset_busy: got %b want 0", bus.MdBusyE); end
    nCmp++;
    if (bus.ALUOutE !== '0 || bus.WriteDataE !== '0 || bus.WriteRegE !== '0 || bus.RsE !== '0 ||
        bus.RtE !== '0 || bus.RegWriteE !== 1'b0 || bus.MdStallE !== 1'b0) begin
      nErr++; $display("FAIL midop_reset_outputs: got alu=%h wd=%h wr=%0d rs=%0d rt=%0d rw=%b want all 0",
        bus.ALUOutE, bus.WriteDataE, bus.WriteRegE, bus.RsE, bus.RtE, bus.RegWriteE);
    end
    rst_n = 1; mHi = '0; mLo = '0;
    readHiLo(h, l);
    nCmp++; if (h !== mHi || l !== mLo) begin
      nErr++; $display("FAIL midop_reset_hilo: got hi=%h lo=%h want 0", h, l);
    end
  endtask

  initial begin
    rst_n = 0;
    clearD();
    test_reset();
    test_wb_mux();
    test_forward();
    test_alu_random();
    test_mult();
    test_no_relaunch();
    test_div();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
